// File: rtl/topk_sort_scheduler_pkg.sv
// Shared definitions for the top-K sort scheduler.
//   state_t      : LOAD / SORT / DRAIN controller states
//   fp32 offsets : sign bit, exponent field and fraction field positions
//   sort_cycles  : length of the SORT state for an N-entry batch
package topk_sort_scheduler_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    // Even phases issue n/2 pairs and odd phases issue n/2-1 pairs.
    // Each phase is followed by one bubble cycle.
    function automatic int sort_cycles(input int n);
        return (n / 2) * (n / 2 + 1) + (n / 2) * (n / 2);
    endfunction

endpackage

// File: rtl/cmp_xchg_fp32.sv
// Registered compare-exchange unit for fp32 words, ordered by magnitude.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid, a, b  : pair to order; a comes from the lower buffer index
//   out_valid       : lo/hi carry the ordered result of the previous cycle
//   lo, hi          : words destined for the lower and the higher buffer index
// When DESCENDING=1, lo receives the larger magnitude. Equal magnitudes
// never swap, which keeps the surrounding transposition sort stable.
module cmp_xchg_fp32
    import topk_sort_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit DESCENDING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    // The magnitude key is every bit below the sign: exponent above
    // fraction, so an unsigned compare checks exponent first.
    localparam int KEY_W = SIGN_BIT;

    logic [KEY_W-1:0]      key_a;
    logic [KEY_W-1:0]      key_b;
    logic                  swap;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] lo_reg;
    logic [DATA_WIDTH-1:0] hi_reg;

    assign key_a = {a[EXP_MSB:EXP_LSB], a[FRAC_MSB:FRAC_LSB]};
    assign key_b = {b[EXP_MSB:EXP_LSB], b[FRAC_MSB:FRAC_LSB]};
    assign swap  = DESCENDING ? (key_b > key_a) : (key_a > key_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            lo_reg        <= '0;
            hi_reg        <= '0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                lo_reg <= swap ? b : a;
                hi_reg <= swap ? a : b;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign lo        = lo_reg;
    assign hi        = hi_reg;

endmodule

// File: rtl/topk_sort_scheduler.sv
// Batch top-K sorter: loads N fp32 words, sorts them by magnitude with an
// odd-even transposition sort through one shared compare-exchange unit,
// then streams out the first K entries.
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      : load stream, accepted only in LOAD
//   out_valid/out_ready/out_data   : ranked results, presented only in DRAIN
//   out_last                       : marks the K-th result of the batch
//   busy                           : high while sorting or draining
module topk_sort_scheduler
    import topk_sort_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 8,
    parameter int K          = 4,
    parameter int DESCENDING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int IDX_W  = $clog2(N);
    localparam int PAIR_W = $clog2(N / 2 + 1);

    localparam logic [IDX_W-1:0]  LAST_ENTRY = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  LAST_OUT   = IDX_W'(K - 1);
    localparam logic [PAIR_W-1:0] EVEN_PAIRS = PAIR_W'(N / 2);
    localparam logic [PAIR_W-1:0] ODD_PAIRS  = PAIR_W'(N / 2 - 1);

    state_t                      state_reg;
    logic [IDX_W-1:0]            load_cnt_reg;
    logic [IDX_W-1:0]            pass_reg;
    logic [PAIR_W-1:0]           pair_reg;
    logic [IDX_W-1:0]            out_idx_reg;
    logic [IDX_W-1:0]            wb_idx_reg;
    logic                        in_ready_reg;
    logic                        out_valid_reg;
    logic                        out_last_reg;

    logic [N-1:0][DATA_WIDTH-1:0] buf_words;

    logic                        phase_odd;
    logic [PAIR_W-1:0]           phase_pairs;
    logic                        issue;
    logic [IDX_W-1:0]            issue_idx;
    logic [IDX_W-1:0]            issue_idx_hi;
    logic [IDX_W-1:0]            wb_idx_hi;
    logic                        load_fire;
    logic                        drain_fire;

    logic                        cx_valid;
    logic [DATA_WIDTH-1:0]       cx_lo;
    logic [DATA_WIDTH-1:0]       cx_hi;

    // Pair k of a phase starts at index 2k (even phase) or 2k+1 (odd phase).
    // Once pair_reg reaches phase_pairs the cycle is the bubble that lets the
    // last write-back of the phase land before the next phase reads.
    assign phase_odd    = pass_reg[0];
    assign phase_pairs  = phase_odd ? ODD_PAIRS : EVEN_PAIRS;
    assign issue        = (state_reg == SORT) && (pair_reg < phase_pairs);
    assign issue_idx    = IDX_W'({pair_reg, phase_odd});
    assign issue_idx_hi = issue_idx + IDX_W'(1);
    assign wb_idx_hi    = wb_idx_reg + IDX_W'(1);

    assign load_fire  = (state_reg == LOAD) && in_valid && in_ready_reg;
    assign drain_fire = (state_reg == DRAIN) && out_ready;

    cmp_xchg_fp32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DESCENDING (DESCENDING != 0)
    ) u_cmp_xchg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .a         (buf_words[issue_idx]),
        .b         (buf_words[issue_idx_hi]),
        .out_valid (cx_valid),
        .lo        (cx_lo),
        .hi        (cx_hi)
    );

    // One register per buffer entry: written by the load stream in LOAD,
    // or by the compare-exchange result when its pair covers this entry.
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
        logic [DATA_WIDTH-1:0] entry_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (load_fire && (load_cnt_reg == IDX_W'(gi))) begin
                entry_reg <= in_data;
            end else if (cx_valid && (wb_idx_reg == IDX_W'(gi))) begin
                entry_reg <= cx_lo;
            end else if (cx_valid && (wb_idx_hi == IDX_W'(gi))) begin
                entry_reg <= cx_hi;
            end
        end

        assign buf_words[gi] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD;
            load_cnt_reg  <= '0;
            pass_reg      <= '0;
            pair_reg      <= '0;
            out_idx_reg   <= '0;
            wb_idx_reg    <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    in_ready_reg <= 1'b1;
                    if (load_fire) begin
                        if (load_cnt_reg == LAST_ENTRY) begin
                            load_cnt_reg <= '0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= SORT;
                        end else begin
                            load_cnt_reg <= load_cnt_reg + IDX_W'(1);
                        end
                    end
                end

                SORT: begin
                    if (issue) begin
                        wb_idx_reg <= issue_idx;
                    end
                    if (pair_reg == phase_pairs) begin
                        pair_reg <= '0;
                        if (pass_reg == LAST_ENTRY) begin
                            // The final write-back lands on this same edge.
                            pass_reg      <= '0;
                            out_idx_reg   <= '0;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (K == 1);
                            state_reg     <= DRAIN;
                        end else begin
                            pass_reg <= pass_reg + IDX_W'(1);
                        end
                    end else begin
                        pair_reg <= pair_reg + PAIR_W'(1);
                    end
                end

                DRAIN: begin
                    if (drain_fire) begin
                        if (out_idx_reg == LAST_OUT) begin
                            out_idx_reg   <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= LOAD;
                        end else begin
                            out_idx_reg  <= out_idx_reg + IDX_W'(1);
                            out_last_reg <= ((out_idx_reg + IDX_W'(1)) == LAST_OUT);
                        end
                    end
                end

                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_valid_reg ? buf_words[out_idx_reg] : '0;
    assign busy      = (state_reg != LOAD);

endmodule

// File: tb/tb_topk_sort_scheduler.sv
// Randomized self-checking bench for topk_sort_scheduler (N=8, K=4,
// descending). Expected results come from a stable insertion sort on
// magnitude keys kept in the bench.
module tb_topk_sort_scheduler;
    import topk_sort_scheduler_pkg::*;

    localparam int DW   = 32;
    localparam int N    = 8;
    localparam int K    = 4;
    localparam int DESC = 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int batch_no = 0;

    logic [31:0] batch    [N];
    logic [31:0] expect_q [N];

    topk_sort_scheduler #(
        .DATA_WIDTH (DW),
        .N          (N),
        .K          (K),
        .DESCENDING (DESC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (batch %0d)", tag, got, exp, batch_no);
        end
    endtask

    // Strict "ranks ahead of" on the sign-less magnitude.
    function automatic bit ranks_before(input logic [31:0] x, input logic [31:0] y);
        logic [30:0] mx;
        logic [30:0] my;
        mx = x[30:0];
        my = y[30:0];
        if (DESC != 0) return mx > my;
        return mx < my;
    endfunction

    task automatic build_expected();
        logic [31:0] tmp;
        int j;
        for (int i = 0; i < N; i++) expect_q[i] = batch[i];
        for (int i = 1; i < N; i++) begin
            tmp = expect_q[i];
            j = i - 1;
            while (j >= 0 && ranks_before(tmp, expect_q[j])) begin
                expect_q[j + 1] = expect_q[j];
                j--;
            end
            expect_q[j + 1] = tmp;
        end
    endtask

    // Returns on the negedge whose following posedge takes the N-th word.
    task automatic load_only();
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < N && guard < 500) begin
            @(negedge clk);
            guard++;
            in_valid = ($urandom_range(3) != 0);
            in_data  = batch[idx];
            if (in_valid && in_ready) idx++;
        end
        if (idx < N) check("load_timeout", 32'(idx), 32'(N));
    endtask

    task automatic run_batch(input int hold_cycles, input bit poke, input bit full_rate);
        int lat;
        int idx;
        int guard;
        build_expected();
        load_only();
        @(negedge clk);
        in_valid = poke;
        in_data  = $urandom();
        check("in_ready_sort", 32'(in_ready), 32'd0);
        check("busy_sort", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            out_ready = $urandom_range(1) != 0;
            @(negedge clk);
            lat++;
            if (poke) begin
                in_valid = 1'b1;
                in_data  = $urandom();
            end
            if (!out_valid) check("in_ready_sort", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(lat), 32'(sort_cycles(N)));

        idx = 0;
        guard = 0;
        while (idx < K && guard < 500) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", out_data, expect_q[idx]);
            check("out_last", 32'(out_last), 32'(idx == K - 1));
            check("in_ready_drain", 32'(in_ready), 32'd0);
            check("busy_drain", 32'(busy), 32'd1);
            out_ready = (guard >= hold_cycles) && (full_rate || ($urandom_range(3) != 0));
            if (poke) begin
                in_valid = 1'b1;
                in_data  = $urandom();
            end
            if (out_ready) idx++;
            guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_count", 32'(idx), 32'(K));
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("out_last_after", 32'(out_last), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        $display("batch %0d: top %h %h %h %h latency %0d", batch_no,
                 expect_q[0], expect_q[1], expect_q[2], expect_q[3], lat);
        batch_no++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    task automatic random_batch(input bool_dups);
        logic [31:0] pool [4];
        for (int i = 0; i < 4; i++) pool[i] = {1'b0, 31'($urandom())};
        for (int i = 0; i < N; i++) begin
            if (bool_dups != 0)
                batch[i] = {1'($urandom_range(1)), pool[$urandom_range(3)][30:0]};
            else
                batch[i] = $urandom();
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_release", 32'(in_ready), 32'd1);
        check("out_valid_release", 32'(out_valid), 32'd0);

        // Mixed signs and magnitudes at full output rate.
        batch = '{32'h3F800000, 32'h40A00000, 32'hC0400000, 32'h40000000,
                  32'h3F000000, 32'h41000000, 32'h40E00000, 32'hC0C00000};
        run_batch(0, 1'b0, 1'b1);
        check("directed_first", expect_q[0], 32'h41000000);

        // Already descending; output stalled for 10 cycles.
        batch = '{32'h41100000, 32'h41000000, 32'h40E00000, 32'h40C00000,
                  32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000};
        run_batch(10, 1'b0, 1'b0);

        // Equal magnitudes must keep load order.
        batch = '{32'h40400000, 32'hC0400000, 32'h3F800000, 32'h3F800000,
                  32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_batch(0, 1'b0, 1'b1);

        // Reset in the middle of SORT aborts the batch.
        random_batch(0);
        load_only();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midsort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_abort", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_partial_output", 32'(out_valid), 32'd0);
        end
        batch = '{32'h3F800000, 32'h40A00000, 32'hC0400000, 32'h40000000,
                  32'h3F000000, 32'h41000000, 32'h40E00000, 32'hC0C00000};
        run_batch(0, 1'b0, 1'b1);

        // Back-to-back batches with in_valid driven through SORT and DRAIN.
        random_batch(0);
        run_batch(0, 1'b1, 1'b0);
        random_batch(1);
        run_batch(0, 1'b1, 1'b0);

        for (int b = 0; b < 16; b++) begin
            random_batch(b % 2);
            run_batch($urandom_range(3), b[2], b[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
